// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port data memory: one read then one write per word,
// accumulating an XOR checksum of the copied data and pulsing done at the end of each job.
module mem_copy_engine #(
  parameter int unsigned ADDR_STEP = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_src_addr,
  input  logic [63:0] i_dst_addr,
  input  logic [8:0]  i_count,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_checksum,
  output logic [8:0]  o_words_done,
  output logic [63:0] o_mem_address,
  output logic [63:0] o_mem_write_data,
  output logic        o_mem_write_en,
  output logic        o_mem_read_en,
  input  logic [63:0] i_mem_read_data
);

  // state   | meaning
  // S_IDLE  | waiting for start; memory strobes off
  // S_READ  | reading word at r_cur_src into r_buffer
  // S_WRITE | writing r_buffer to r_cur_dst, advancing pointers
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [63:0] STEP = 64'(ADDR_STEP);

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_cur_src;
  logic [63:0] r_cur_dst;
  logic [63:0] r_buffer;
  logic [63:0] r_checksum;
  logic [8:0]  r_remaining;
  logic [8:0]  r_words_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_count != 9'd0) ? S_READ : S_DONE;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = (r_remaining == 9'd1) ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_buffer     <= '0;
      r_checksum   <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur_src    <= i_src_addr;
            r_cur_dst    <= i_dst_addr;
            r_remaining  <= i_count;
            r_checksum   <= '0;
            r_words_done <= '0;
          end
        end
        S_READ: r_buffer <= i_mem_read_data;
        S_WRITE: begin
          r_checksum   <= r_checksum ^ r_buffer;
          r_words_done <= r_words_done + 9'd1;
          r_cur_src    <= r_cur_src + STEP;
          r_cur_dst    <= r_cur_dst + STEP;
          r_remaining  <= r_remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore decode: strobes depend only on the registered state
  always_comb begin
    o_busy           = 1'b0;
    o_done           = 1'b0;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    o_mem_write_en   = 1'b0;
    o_mem_read_en    = 1'b0;
    case (r_state)
      S_READ: begin
        o_busy        = 1'b1;
        o_mem_read_en = 1'b1;
        o_mem_address = r_cur_src;
      end
      S_WRITE: begin
        o_busy           = 1'b1;
        o_mem_write_en   = 1'b1;
        o_mem_address    = r_cur_dst;
        o_mem_write_data = r_buffer;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_checksum   = r_checksum;
  assign o_words_done = r_words_done;

endmodule
